// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage core: widths, ALU opcodes,
// the ID/EX register layout and the ID/EX control state encoding.
package cpu_pkg;

    localparam int DW   = 16;   // datapath width (RF data, imm, pc)
    localparam int AW   = 4;    // register address width
    localparam int OPW  = 4;    // ALU opcode width
    localparam int CNTW = 16;   // default performance counter width

    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_PASS = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_R12  = 4'd12,
        ALU_R13  = 4'd13,
        ALU_R14  = 4'd14,
        ALU_R15  = 4'd15
    } alu_op_t;

    // RUN: normal flow, BUBBLE: a load-use bubble was just inserted,
    // HOLD: the register is frozen by a downstream stall.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } idex_state_t;

    // Everything the EX stage consumes from ID/EX.
    typedef struct packed {
        logic          vld;
        logic [DW-1:0] p0;
        logic [DW-1:0] p1;
        logic [AW-1:0] p0_addr;
        logic [AW-1:0] p1_addr;
        logic [AW-1:0] dst_addr;
        logic          we;
        logic          ld;
        logic          st;
        alu_op_t       alu_op;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
    } idex_t;

endpackage

// File: rtl/ld_use_detect.sv
// Load-use hazard compare: a load sitting in the producing stage whose
// destination is read by the consuming instruction. Purely combinational
// so it can be reused for later-stage checks.
module ld_use_detect
    import cpu_pkg::*;
#(
    parameter int AW = cpu_pkg::AW
) (
    input  logic          prod_vld,
    input  logic          prod_ld,
    input  logic          prod_we,
    input  logic [AW-1:0] prod_dst,
    input  logic          cons_vld,
    input  logic          cons_re0,
    input  logic          cons_re1,
    input  logic [AW-1:0] cons_a0,
    input  logic [AW-1:0] cons_a1,
    output logic          hz
);

    logic match0;
    logic match1;
    logic prod_live;

    // Register 0 is hardwired to zero, so a load "into" it never hazards.
    always_comb begin
        prod_live = prod_vld & prod_ld & prod_we & (|prod_dst);
        match0    = cons_re0 & (cons_a0 == prod_dst);
        match1    = cons_re1 & (cons_a1 == prod_dst);
        hz        = prod_live & cons_vld & (match0 | match1);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures RF read data and decoded fields,
// inserts a single bubble on load-use, honours downstream stall and
// branch flush, and counts inserted bubbles (saturating).
// The register layout comes from cpu_pkg; DW/AW/OPW are expected to
// match the package values.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW   = cpu_pkg::DW,
    parameter int AW   = cpu_pkg::AW,
    parameter int OPW  = cpu_pkg::OPW,
    parameter int CNTW = cpu_pkg::CNTW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_vld,
    input  logic [AW-1:0]   id_p0_addr,
    input  logic [AW-1:0]   id_p1_addr,
    input  logic            id_re0,
    input  logic            id_re1,
    input  logic [DW-1:0]   id_p0,
    input  logic [DW-1:0]   id_p1,
    input  logic [AW-1:0]   id_dst_addr,
    input  logic            id_we,
    input  logic            id_ld,
    input  logic            id_st,
    input  logic [OPW-1:0]  id_alu_op,
    input  logic [DW-1:0]   id_imm,
    input  logic [DW-1:0]   id_pc,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            stall_id,
    output logic            ex_vld,
    output logic [DW-1:0]   ex_p0,
    output logic [DW-1:0]   ex_p1,
    output logic [AW-1:0]   ex_p0_addr,
    output logic [AW-1:0]   ex_p1_addr,
    output logic [AW-1:0]   ex_dst_addr,
    output logic            ex_we,
    output logic            ex_ld,
    output logic            ex_st,
    output logic [OPW-1:0]  ex_alu_op,
    output logic [DW-1:0]   ex_imm,
    output logic [DW-1:0]   ex_pc,
    output logic [CNTW-1:0] ld_use_cnt
);

    idex_t         r;
    idex_state_t   state;
    logic [CNTW-1:0] cnt;
    logic          hz;
    idex_t         id_pkt;

    ld_use_detect #(.AW(AW)) u_hz (
        .prod_vld (r.vld),
        .prod_ld  (r.ld),
        .prod_we  (r.we),
        .prod_dst (r.dst_addr),
        .cons_vld (id_vld),
        .cons_re0 (id_re0),
        .cons_re1 (id_re1),
        .cons_a0  (id_p0_addr),
        .cons_a1  (id_p1_addr),
        .hz       (hz)
    );

    // Assemble the incoming ID fields into register layout.
    always_comb begin
        id_pkt          = '0;
        id_pkt.vld      = id_vld;
        id_pkt.p0       = id_p0;
        id_pkt.p1       = id_p1;
        id_pkt.p0_addr  = id_p0_addr;
        id_pkt.p1_addr  = id_p1_addr;
        id_pkt.dst_addr = id_dst_addr;
        id_pkt.we       = id_we;
        id_pkt.ld       = id_ld;
        id_pkt.st       = id_st;
        id_pkt.alu_op   = alu_op_t'(id_alu_op);
        id_pkt.imm      = id_imm;
        id_pkt.pc       = id_pc;
    end

    // Hold IF/ID on downstream stall, or on a hazard that a flush is not
    // about to make irrelevant. Forced low while in reset.
    always_comb begin
        stall_id = rst_n & (ex_stall | (hz & ~flush));
    end

    // ID/EX register, control state and bubble counter.
    // Priority: reset > flush > ex_stall > hazard > normal capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r     <= '0;
            cnt   <= '0;
            state <= RUN;
        end else if (flush) begin
            // Only the control bits matter once the slot is dead.
            r.vld <= 1'b0;
            r.we  <= 1'b0;
            r.ld  <= 1'b0;
            r.st  <= 1'b0;
            state <= RUN;
        end else if (ex_stall) begin
            state <= HOLD;
        end else if (hz) begin
            // Bubble must not write the RF or match any forwarding path.
            r.vld <= 1'b0;
            r.we  <= 1'b0;
            r.ld  <= 1'b0;
            r.st  <= 1'b0;
            if (!(&cnt)) cnt <= cnt + 1'b1;
            state <= BUBBLE;
        end else begin
            r     <= id_pkt;
            state <= RUN;
        end
    end

    // A bubble is always a dead slot, and since it carries no load it can
    // never trigger a second consecutive bubble.
    bubble_is_dead: assert property (@(posedge clk) disable iff (!rst_n)
        (state == BUBBLE) |-> (!ex_vld && !ex_we && !ex_ld));
    single_bubble: assert property (@(posedge clk) disable iff (!rst_n)
        (state == BUBBLE) |=> (state != BUBBLE));

    // Drive the flat EX-side ports from the register.
    always_comb begin
        ex_vld      = r.vld;
        ex_p0       = r.p0;
        ex_p1       = r.p1;
        ex_p0_addr  = r.p0_addr;
        ex_p1_addr  = r.p1_addr;
        ex_dst_addr = r.dst_addr;
        ex_we       = r.we;
        ex_ld       = r.ld;
        ex_st       = r.st;
        ex_alu_op   = r.alu_op;
        ex_imm      = r.imm;
        ex_pc       = r.pc;
        ld_use_cnt  = cnt;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model computes the
// expected ID/EX contents each cycle, pushes them to a queue, and the
// entry is popped and compared after the clock edge.
module tb_id_ex_stage;
    import cpu_pkg::*;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_vld, id_re0, id_re1, id_we, id_ld, id_st;
    logic [3:0]    id_p0_addr, id_p1_addr, id_dst_addr, id_alu_op;
    logic [15:0]   id_p0, id_p1, id_imm, id_pc;
    logic          ex_stall, flush, stall_id;
    logic          ex_vld, ex_we, ex_ld, ex_st;
    logic [15:0]   ex_p0, ex_p1, ex_imm, ex_pc;
    logic [3:0]    ex_p0_addr, ex_p1_addr, ex_dst_addr, ex_alu_op;
    logic [CW-1:0] ld_use_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(16), .AW(4), .OPW(4), .CNTW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_vld(id_vld),
        .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr),
        .id_re0(id_re0), .id_re1(id_re1), .id_p0(id_p0), .id_p1(id_p1),
        .id_dst_addr(id_dst_addr), .id_we(id_we), .id_ld(id_ld), .id_st(id_st),
        .id_alu_op(id_alu_op), .id_imm(id_imm), .id_pc(id_pc),
        .ex_stall(ex_stall), .flush(flush), .stall_id(stall_id),
        .ex_vld(ex_vld), .ex_p0(ex_p0), .ex_p1(ex_p1),
        .ex_p0_addr(ex_p0_addr), .ex_p1_addr(ex_p1_addr), .ex_dst_addr(ex_dst_addr),
        .ex_we(ex_we), .ex_ld(ex_ld), .ex_st(ex_st), .ex_alu_op(ex_alu_op),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ld_use_cnt(ld_use_cnt)
    );

    typedef struct {
        logic          vld, we, ld, st;
        logic [3:0]    p0a, p1a, dst, op;
        logic [15:0]   p0, p1, imm, pc;
        logic [CW-1:0] cnt;
        logic          full;     // data fields are meaningful
        idex_state_t   fsm;
    } exp_t;

    exp_t m;
    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic m_reset();
        m.vld = 0; m.we = 0; m.ld = 0; m.st = 0;
        m.p0a = 0; m.p1a = 0; m.dst = 0; m.op = 0;
        m.p0 = 0; m.p1 = 0; m.imm = 0; m.pc = 0;
        m.cnt = 0; m.full = 1; m.fsm = RUN;
    endtask

    task automatic drv(input logic v, input logic [3:0] a0, input logic [3:0] a1,
                       input logic r0, input logic r1, input logic [3:0] dst,
                       input logic we, input logic ld, input logic st,
                       input logic [3:0] op);
        id_vld = v; id_p0_addr = a0; id_p1_addr = a1; id_re0 = r0; id_re1 = r1;
        id_dst_addr = dst; id_we = we; id_ld = ld; id_st = st; id_alu_op = op;
        id_p0 = 16'($urandom); id_p1 = 16'($urandom);
        id_imm = 16'($urandom); id_pc = 16'($urandom);
    endtask

    task automatic compare(input exp_t e);
        chk("ctrl", {ex_vld, ex_we, ex_ld, ex_st}, {e.vld, e.we, e.ld, e.st});
        chk("ld_use_cnt", ld_use_cnt, e.cnt);
        chk("state", dut.state, e.fsm);
        if (e.full) begin
            chk("data", {ex_p0, ex_p1, ex_imm, ex_pc}, {e.p0, e.p1, e.imm, e.pc});
            chk("addr", {ex_p0_addr, ex_p1_addr, ex_dst_addr, ex_alu_op},
                        {e.p0a, e.p1a, e.dst, e.op});
        end
    endtask

    // One clock: check comb stall_id, advance the model, compare after edge.
    task automatic cyc(input logic fl, input logic sl);
        logic hz;
        flush = fl; ex_stall = sl;
        #1;
        hz = m.vld & m.ld & m.we & (m.dst != 4'd0) & id_vld &
             ((id_re0 & (id_p0_addr == m.dst)) | (id_re1 & (id_p1_addr == m.dst)));
        chk("stall_id", stall_id, sl | (hz & ~fl));
        if (fl) begin
            m.vld = 0; m.we = 0; m.ld = 0; m.st = 0; m.full = 0; m.fsm = RUN;
        end else if (sl) begin
            m.fsm = HOLD;
        end else if (hz) begin
            m.vld = 0; m.we = 0; m.ld = 0; m.st = 0; m.full = 0; m.fsm = BUBBLE;
            if (m.cnt != {CW{1'b1}}) m.cnt = m.cnt + 1'b1;
        end else begin
            m.vld = id_vld; m.we = id_we; m.ld = id_ld; m.st = id_st;
            m.p0a = id_p0_addr; m.p1a = id_p1_addr; m.dst = id_dst_addr; m.op = id_alu_op;
            m.p0 = id_p0; m.p1 = id_p1; m.imm = id_imm; m.pc = id_pc;
            m.full = 1; m.fsm = RUN;
        end
        q.push_back(m);
        @(posedge clk); #1;
        compare(q.pop_front());
    endtask

    task automatic do_reset(input logic fl, input logic sl, input logic chk_stall);
        rst_n = 1'b0; flush = fl; ex_stall = sl;
        #1;
        if (chk_stall) chk("rst_stall_id", stall_id, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        q.push_back(m);
        compare(q.pop_front());
        if (chk_stall) chk("rst_stall_id2", stall_id, 1'b0);
        rst_n = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0; flush = 1'b0; ex_stall = 1'b0;
        drv(1, 4'd1, 4'd2, 1, 1, 4'd5, 1, 0, 0, ALU_ADD);
        @(posedge clk); #1;
        do_reset(1'b0, 1'b0, 1'b1);

        // first instruction after reset captured on next edge
        cyc(0, 0);

        // LD R3; ADD R4,R3,R5 -> one bubble then ADD
        drv(1, 4'd1, 4'd0, 1, 0, 4'd3, 1, 1, 0, ALU_ADD); cyc(0, 0);
        drv(1, 4'd3, 4'd5, 1, 1, 4'd4, 1, 0, 0, ALU_ADD); cyc(0, 0); cyc(0, 0);

        // LD R0 then ADD reading R0: no hazard
        drv(1, 4'd1, 4'd0, 1, 0, 4'd0, 1, 1, 0, ALU_ADD); cyc(0, 0);
        drv(1, 4'd0, 4'd2, 1, 1, 4'd4, 1, 0, 0, ALU_ADD); cyc(0, 0);
        // LD R3 then instruction naming R3 but not using it
        drv(1, 4'd1, 4'd0, 1, 0, 4'd3, 1, 1, 0, ALU_ADD); cyc(0, 0);
        drv(1, 4'd3, 4'd3, 0, 0, 4'd4, 1, 0, 0, ALU_PASS); cyc(0, 0);

        // hazard through source 1
        drv(1, 4'd1, 4'd0, 1, 0, 4'd6, 1, 1, 0, ALU_ADD); cyc(0, 0);
        drv(1, 4'd2, 4'd6, 1, 1, 4'd7, 1, 0, 1, ALU_SUB); cyc(0, 0); cyc(0, 0);

        // downstream stall for 3 cycles with changing ID
        drv(1, 4'd1, 4'd2, 1, 1, 4'd9, 1, 1, 0, ALU_ADD); cyc(0, 0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 4'($urandom), 4'($urandom), 1, 1, 4'($urandom), 1, 0, 0, ALU_XOR);
            cyc(0, 1);
        end
        drv(1, 4'd1, 4'd2, 1, 1, 4'd8, 1, 0, 0, ALU_OR); cyc(0, 0);

        // flush concurrent with hazard, then with ex_stall
        drv(1, 4'd1, 4'd0, 1, 0, 4'd7, 1, 1, 0, ALU_ADD); cyc(0, 0);
        drv(1, 4'd7, 4'd1, 1, 0, 4'd2, 1, 0, 0, ALU_ADD); cyc(1, 0);
        drv(1, 4'd1, 4'd0, 1, 0, 4'd7, 1, 1, 0, ALU_ADD); cyc(0, 0);
        drv(1, 4'd7, 4'd1, 1, 0, 4'd2, 1, 0, 0, ALU_ADD); cyc(1, 1);
        cyc(0, 0);

        // counter saturation at 2'b11
        for (int i = 0; i < 5; i++) begin
            drv(1, 4'd1, 4'd0, 1, 0, 4'd2, 1, 1, 0, ALU_ADD); cyc(0, 0);
            drv(1, 4'd2, 4'd3, 1, 1, 4'd5, 1, 0, 0, ALU_ADD); cyc(0, 0); cyc(0, 0);
        end

        // reset wins over flush and stall; next cycle captures normally
        drv(1, 4'd1, 4'd0, 1, 0, 4'd3, 1, 1, 0, ALU_ADD); cyc(0, 0);
        do_reset(1'b1, 1'b1, 1'b0);
        drv(1, 4'd3, 4'd4, 1, 1, 4'd6, 1, 0, 1, ALU_AND); cyc(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
